// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, address-width helper and read-port state type.
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int DEPTH_DEF = 32;
  localparam int NREAD_DEF = 2;
  typedef enum logic {PS_IDLE, PS_VALID} port_state_e;
  function automatic int aw_of(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/regfile_rport.sv
// regfile_rport: one read port - lookup with zero/range masking, write bypass,
// and an optional registered output with a two-state valid FSM.
module regfile_rport
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AW       = aw_of(DEPTH_DEF),
  parameter int ZERO_REG = 1,
  parameter int REG_RD   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_re,
  input  logic            i_stall,
  input  logic [AW-1:0]   i_raddr,
  input  logic [XLEN-1:0] i_entry,
  input  logic            i_wlegal,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_rvalid
);
  logic            w_illegal;
  logic [XLEN-1:0] w_lookup;
  assign w_illegal = (int'(i_raddr) >= DEPTH) || (ZERO_REG != 0 && i_raddr == '0);
  assign w_lookup  = w_illegal ? '0 : (i_wlegal && i_waddr == i_raddr) ? i_wdata : i_entry;
  if (REG_RD != 0) begin : g_reg
    port_state_e     r_state;
    logic [AW-1:0]   r_addr;
    logic [XLEN-1:0] r_data;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= PS_IDLE;
        r_addr  <= '0;
        r_data  <= '0;
      end else if (!i_stall && i_re) begin
        r_state <= PS_VALID;
        r_addr  <= i_raddr;
        r_data  <= w_lookup;
      end else begin
        if (!i_stall) r_state <= PS_IDLE;
        // held data tracks writes to the captured address so it never goes stale
        if (i_wlegal && i_waddr == r_addr) r_data <= i_wdata;
      end
    end
    assign o_rdata  = r_data;
    assign o_rvalid = (r_state == PS_VALID);
  end else begin : g_comb
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst_n, i_re, i_stall};
    assign o_rdata  = w_lookup;
    assign o_rvalid = 1'b1;
  end
endmodule

// File: rtl/regfile_nr1w.sv
// regfile_nr1w: DEPTH x XLEN register file, one write port, NREAD read ports.
module regfile_nr1w
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int NREAD    = NREAD_DEF,
  parameter int ZERO_REG = 1,
  parameter int REG_RD   = 1,
  localparam int AW      = aw_of(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [NREAD-1:0]      re,
  input  logic [NREAD*AW-1:0]   raddr,
  input  logic                  stall,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rvalid
);
  logic [XLEN-1:0] r_mem [DEPTH];
  logic            w_wlegal;
  assign w_wlegal = we && (int'(waddr) < DEPTH) && !(ZERO_REG != 0 && waddr == '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (w_wlegal) begin
      r_mem[waddr] <= wdata;
    end
  end
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_ent;
    assign w_ra  = raddr[i*AW +: AW];
    // out-of-range entries are masked to zero inside the port
    assign w_ent = r_mem[w_ra];
    regfile_rport #(
      .XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .REG_RD(REG_RD)
    ) u_rport (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_re    (re[i]),
      .i_stall (stall),
      .i_raddr (w_ra),
      .i_entry (w_ent),
      .i_wlegal(w_wlegal),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .o_rdata (rdata[i*XLEN +: XLEN]),
      .o_rvalid(rvalid[i])
    );
  end
endmodule

// File: tb/tb_regfile_nr1w.sv
// tb_regfile_nr1w: directed table-driven bench over four parameterisations sharing inputs.
module tb_regfile_nr1w;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  re = '0;
  logic [9:0]  raddr = '0;
  logic        stall = 1'b0;
  logic [63:0] rd_main, rd_z0, rd_d24, rd_comb;
  logic [1:0]  rv_main, rv_z0, rv_d24, rv_comb;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_nr1w u_main (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .stall(stall), .rdata(rd_main), .rvalid(rv_main));
  regfile_nr1w #(.ZERO_REG(0)) u_z0 (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .stall(stall), .rdata(rd_z0), .rvalid(rv_z0));
  regfile_nr1w #(.DEPTH(24)) u_d24 (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .stall(stall), .rdata(rd_d24), .rvalid(rv_d24));
  regfile_nr1w #(.REG_RD(0)) u_comb (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .stall(stall), .rdata(rd_comb), .rvalid(rv_comb));

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  re;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        st;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  v;
  } vec_t;
  vec_t vecs [14];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 2'b10, 5'd0,  5'd5, 1'b0, 32'h0,        32'hDEADBEEF, 2'b10};
    vecs[1]  = '{1'b1, 5'd0,  32'h12345678, 2'b11, 5'd5,  5'd0, 1'b0, 32'hDEADBEEF, 32'h0,        2'b11};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd0,  5'd5, 1'b0, 32'h0,        32'hDEADBEEF, 2'b11};
    vecs[3]  = '{1'b1, 5'd7,  32'h11,       2'b01, 5'd7,  5'd5, 1'b0, 32'h11,       32'hDEADBEEF, 2'b01};
    vecs[4]  = '{1'b1, 5'd5,  32'h55,       2'b00, 5'd7,  5'd5, 1'b0, 32'h11,       32'h55,       2'b00};
    vecs[5]  = '{1'b1, 5'd3,  32'h33,       2'b00, 5'd7,  5'd5, 1'b0, 32'h11,       32'h55,       2'b00};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd5,  5'd5, 1'b0, 32'h55,       32'h55,       2'b11};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        2'b01, 5'd7,  5'd5, 1'b0, 32'h11,       32'h55,       2'b01};
    vecs[8]  = '{1'b1, 5'd7,  32'h22,       2'b11, 5'd3,  5'd3, 1'b1, 32'h22,       32'h55,       2'b01};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd3,  5'd3, 1'b1, 32'h22,       32'h55,       2'b01};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd3,  5'd3, 1'b1, 32'h22,       32'h55,       2'b01};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        2'b01, 5'd3,  5'd3, 1'b0, 32'h33,       32'h55,       2'b01};
    vecs[12] = '{1'b1, 5'd30, 32'hAA,       2'b01, 5'd30, 5'd3, 1'b0, 32'hAA,       32'h55,       2'b01};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        2'b01, 5'd7,  5'd3, 1'b0, 32'h22,       32'h55,       2'b01};

    // requests during reset must leave no trace
    we = 1'b1; waddr = 5'd4; wdata = 32'h44; re = 2'b11; raddr = {5'd4, 5'd4};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", rd_main, 64'h0);
    chk("reset_rvalid", {62'h0, rv_main}, 64'h0);
    chk("reset_comb_rvalid", {62'h0, rv_comb}, 64'h3);
    we = 1'b0; re = 2'b00; raddr = '0;
    #2 rst_n = 1'b1;

    for (int a = 0; a < 32; a++) begin
      re = 2'b01;
      raddr = {5'd0, 5'(a)};
      tick();
      chk($sformatf("scan_d0_a%0d", a), {32'h0, rd_main[31:0]}, 64'h0);
      chk($sformatf("scan_v0_a%0d", a), {63'h0, rv_main[0]}, 64'h1);
    end

    for (int n = 0; n < 14; n++) begin
      we = vecs[n].we; waddr = vecs[n].wa; wdata = vecs[n].wd;
      re = vecs[n].re; raddr = {vecs[n].a1, vecs[n].a0}; stall = vecs[n].st;
      tick();
      chk($sformatf("vec%0d_d0", n), {32'h0, rd_main[31:0]}, {32'h0, vecs[n].d0});
      chk($sformatf("vec%0d_d1", n), {32'h0, rd_main[63:32]}, {32'h0, vecs[n].d1});
      chk($sformatf("vec%0d_v", n), {62'h0, rv_main}, {62'h0, vecs[n].v});
    end

    we = 1'b0; stall = 1'b0; re = 2'b11; raddr = {5'd30, 5'd0};
    tick();
    chk("zero_reg_main", {32'h0, rd_main[31:0]}, 64'h0);
    chk("zero_reg_off", {32'h0, rd_z0[31:0]}, 64'h12345678);
    chk("d24_oob_read", {32'h0, rd_d24[63:32]}, 64'h0);
    chk("d32_addr30", {32'h0, rd_main[63:32]}, 64'hAA);

    raddr = {5'd6, 5'd5};
    tick();
    chk("d24_addr5", {32'h0, rd_d24[31:0]}, 64'h55);
    chk("d24_addr6", {32'h0, rd_d24[63:32]}, 64'h0);

    we = 1'b1; waddr = 5'd9; wdata = 32'h99; raddr = {5'd9, 5'd7};
    #1;
    chk("comb_d0", {32'h0, rd_comb[31:0]}, 64'h22);
    chk("comb_bypass", {32'h0, rd_comb[63:32]}, 64'h99);
    chk("comb_rvalid", {62'h0, rv_comb}, 64'h3);
    tick();
    we = 1'b0;
    #1;
    chk("comb_stored", {32'h0, rd_comb[63:32]}, 64'h99);

    #2 rst_n = 1'b0;
    #1;
    chk("async_rdata", rd_main, 64'h0);
    chk("async_rvalid", {62'h0, rv_main}, 64'h0);
    chk("async_comb", rd_comb, 64'h0);
    #2 rst_n = 1'b1;
    raddr = {5'd7, 5'd5};
    tick();
    chk("post_reset_rdata", rd_main, 64'h0);
    chk("post_reset_rvalid", {62'h0, rv_main}, 64'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_nr1w.md
REGFILE_NR1W -- requirements
Module: regfile_nr1w

Interface
REQ-001 Parameter XLEN, default 32, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 32, number of registers (2..256, need not be a power of two).
REQ-003 Parameter NREAD, default 2, number of independent read ports (1..8).
REQ-004 Parameter ZERO_REG, default 1, register 0 hardwired to zero when 1.
REQ-005 Parameter REG_RD, default 1, read ports registered (1) or combinational (0).
REQ-006 Derived constant AW = max(1, clog2(DEPTH)), address width.
REQ-007 clk  input  1  single clock, all state updates on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 we  input  1  write enable.
REQ-010 waddr  input  AW  write address.
REQ-011 wdata  input  XLEN  write data.
REQ-012 re  input  NREAD  per-port read request (used only when REG_RD=1).
REQ-013 raddr  input  NREAD*AW  packed read addresses, port i at bits [i*AW +: AW].
REQ-014 stall  input  1  holds all read-port output state when 1 (REG_RD=1 only).
REQ-015 rdata  output  NREAD*XLEN  packed read data, port i at bits [i*XLEN +: XLEN].
REQ-016 rvalid  output  NREAD  per-port read data valid (REG_RD=1); tied to all-ones when REG_RD=0.

Function
REQ-017 Write: at rising clk with we=1, entry[waddr] <= wdata, unless waddr>=DEPTH or (ZERO_REG=1 and waddr=0), which are silently ignored.
REQ-018 Lookup value for port i: 0 if raddr_i>=DEPTH or (ZERO_REG=1 and raddr_i=0); else wdata if a legal write to raddr_i is presented this cycle (write-through bypass); else entry[raddr_i].
REQ-019 REG_RD=0: rdata_i equals the lookup value combinationally, zero latency, re and stall ignored.
REQ-020 REG_RD=1, stall=0: at rising clk, port i with re_i=1 captures the lookup value and raddr_i, sets rvalid_i=1; port with re_i=0 clears rvalid_i and holds rdata_i; latency exactly 1 cycle.
REQ-021 REG_RD=1, stall=1: rdata_i, captured address and rvalid_i held; re and raddr ignored.
REQ-022 Coherence: while holding (stall=1 or re_i=0), a legal write to port i's captured address updates rdata_i with wdata at that edge, so held data never goes stale.
REQ-023 Writes proceed regardless of stall.
REQ-024 Multiple ports reading the same address in the same cycle return identical data.
REQ-025 Per-port state is an explicit two-state machine: IDLE (rvalid=0) and VALID (rvalid=1); IDLE->VALID on re&!stall; VALID->IDLE on !re&!stall; all other cases hold.

Reset
REQ-026 rst_n=0 asynchronously clears every storage entry, every rdata_i, every captured address and every rvalid_i to 0; all ports enter IDLE.
REQ-027 Write or read requests coincident with reset assertion have no effect; first capture occurs at the first rising clk after rst_n deasserts.

Structure
REQ-028 Shared package regfile_pkg holds default XLEN/DEPTH/NREAD constants and the clog2 address-width function.
REQ-029 One sub-module regfile_rport (lookup, bypass, port FSM, output register) instantiated NREAD times via generate; storage array and write logic remain in regfile_nr1w.

Verification
REQ-030 Reset then REG_RD=1: read all 32 addresses on port 0 -> rdata=0, rvalid=1 one cycle after each re.
REQ-031 Write 0xDEADBEEF to addr 5 while port 1 reads addr 5 same cycle -> port 1 rdata=0xDEADBEEF next cycle (bypass).
REQ-032 Write 0x12345678 to addr 0 with ZERO_REG=1 -> subsequent read of addr 0 returns 0; with ZERO_REG=0 returns 0x12345678.
REQ-033 Port 0 captures addr 7 (0x11), assert stall 3 cycles and write 0x22 to addr 7 during stall -> rdata_0 becomes 0x22, rvalid_0 stays 1, port 0 ignores new raddr until stall drops.
REQ-034 DEPTH=24: write 0xAA to addr 30 and read addr 30 -> write ignored, rdata=0, no entry corrupted.
REQ-035 Assert rst_n low mid-operation between clock edges -> all rdata and rvalid clear immediately, stored data reads 0 after release.
